// File: rtl/lsu_split_if.sv
// Core-request and data-memory signals of the load/store unit.
// slave: the unit itself; master: the environment (execute stage + memory).
interface lsu_split_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  we_i;
    logic [1:0]            type_i;
    logic                  sign_extend_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [31:0]           wdata_i;
    logic                  resp_valid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    logic                  dmem_valid_o;
    logic                  dmem_ready_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_o;
    logic [31:0]           dmem_wdata_o;
    logic [3:0]            dmem_we_o;
    logic [31:0]           dmem_rdata_i;

    modport slave (
        input  req_valid_i, we_i, type_i, sign_extend_i, addr_i, wdata_i,
        input  dmem_ready_i, dmem_rdata_i,
        output req_ready_o, resp_valid_o, rdata_o, err_o,
        output dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o
    );

    modport master (
        output req_valid_i, we_i, type_i, sign_extend_i, addr_i, wdata_i,
        output dmem_ready_i, dmem_rdata_i,
        input  req_ready_o, resp_valid_o, rdata_o, err_o,
        input  dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o
    );
endinterface

// File: rtl/lsu_split.sv
// Registered load/store unit: splits word-boundary-crossing accesses into two
// aligned beats, merges/extends load data, reports illegal, misaligned and timed-out accesses.
module lsu_split #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter bit          MISALIGNED_EN = 1'b1,
    parameter int unsigned TIMEOUT       = 0
) (
    input logic        clk,
    input logic        rst,
    lsu_split_if.slave bus
);

    localparam logic [1:0] DATA_WORD      = 2'b00;
    localparam logic [1:0] DATA_HALF_WORD = 2'b01;
    localparam logic [1:0] DATA_BYTE      = 2'b10;
    localparam logic [1:0] DATA_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic                  we_q;
    logic [1:0]            type_q;
    logic                  sext_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  split_q;
    logic                  err_q;
    logic [31:0]           beat0_q;
    logic [31:0]           beat1_q;
    logic [31:0]           tmo_cnt_q;

    function automatic logic [2:0] size_of(input logic [1:0] t);
        case (t)
            DATA_BYTE:      size_of = 3'd1;
            DATA_HALF_WORD: size_of = 3'd2;
            default:        size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] mask_of(input logic [1:0] t);
        case (t)
            DATA_BYTE:      mask_of = 8'h01;
            DATA_HALF_WORD: mask_of = 8'h03;
            default:        mask_of = 8'h0F;
        endcase
    endfunction

    // Request-side decode, evaluated on the incoming request before it is latched.
    logic [2:0] req_size;
    logic       req_split;
    logic       req_illegal;

    assign req_size    = size_of(bus.type_i);
    assign req_split   = ({1'b0, bus.addr_i[1:0]} + req_size) > 3'd4;
    assign req_illegal = (bus.type_i == DATA_ILLEGAL) || (req_split && !MISALIGNED_EN);

    logic [1:0]            off;
    logic [7:0]            mask8;
    logic [63:0]           data64;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [31:0]           load_raw;
    logic [31:0]           load_val;

    assign off       = addr_q[1:0];
    assign mask8     = mask_of(type_q) << off;
    assign data64    = {32'b0, wdata_q} << {off, 3'b000};
    assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign next_addr = base_addr + ADDR_WIDTH'(4);
    assign load_raw  = 32'({beat1_q, beat0_q} >> {off, 3'b000});

    always_comb begin
        load_val = load_raw;
        case (type_q)
            DATA_BYTE:
                load_val = sext_q ? {{24{load_raw[7]}}, load_raw[7:0]}
                                  : {24'b0, load_raw[7:0]};
            DATA_HALF_WORD:
                load_val = sext_q ? {{16{load_raw[15]}}, load_raw[15:0]}
                                  : {16'b0, load_raw[15:0]};
            default: load_val = load_raw;
        endcase
    end

    logic in_beat;
    logic timeout_hit;

    assign in_beat     = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == 32'(TIMEOUT - 1));

    assign bus.req_ready_o = (state_q == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Ready takes priority over the timeout when both occur in the same beat cycle.
    always_comb begin
        state_d          = state_q;
        bus.dmem_valid_o = 1'b0;
        bus.dmem_addr_o  = '0;
        bus.dmem_we_o    = '0;
        bus.dmem_wdata_o = '0;
        bus.resp_valid_o = 1'b0;
        bus.err_o        = 1'b0;
        bus.rdata_o      = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) state_d = req_illegal ? S_RESP : S_BEAT0;
            end
            S_BEAT0: begin
                bus.dmem_valid_o = 1'b1;
                bus.dmem_addr_o  = base_addr;
                if (we_q) begin
                    bus.dmem_we_o    = mask8[3:0];
                    bus.dmem_wdata_o = data64[31:0];
                end
                if (bus.dmem_ready_i) state_d = split_q ? S_BEAT1 : S_RESP;
                else if (timeout_hit) state_d = S_RESP;
            end
            S_BEAT1: begin
                bus.dmem_valid_o = 1'b1;
                bus.dmem_addr_o  = next_addr;
                if (we_q) begin
                    bus.dmem_we_o    = mask8[7:4];
                    bus.dmem_wdata_o = data64[63:32];
                end
                if (bus.dmem_ready_i || timeout_hit) state_d = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.err_o        = err_q;
                bus.rdata_o      = (!err_q && !we_q) ? load_val : '0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            type_q    <= '0;
            sext_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            beat0_q   <= '0;
            beat1_q   <= '0;
            tmo_cnt_q <= '0;
        end else if (state_q == S_IDLE && bus.req_valid_i) begin
            we_q      <= bus.we_i;
            type_q    <= bus.type_i;
            sext_q    <= bus.sign_extend_i;
            addr_q    <= bus.addr_i;
            wdata_q   <= bus.wdata_i;
            split_q   <= req_split;
            err_q     <= req_illegal;
            beat0_q   <= '0;
            beat1_q   <= '0;
            tmo_cnt_q <= '0;
        end else if (in_beat) begin
            if (bus.dmem_ready_i) begin
                if (state_q == S_BEAT0) beat0_q <= bus.dmem_rdata_i;
                else                    beat1_q <= bus.dmem_rdata_i;
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
                if (timeout_hit) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_split.sv
// Directed bench for lsu_split: dut_a (split enabled, TIMEOUT=4) and
// dut_b (split disabled, no timeout) share stimulus, selected by sel.
module tb_lsu_split;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  ty = WORD;
    logic        sext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_split_if #(.ADDR_WIDTH(32)) bus_a ();
    lsu_split_if #(.ADDR_WIDTH(32)) bus_b ();

    lsu_split #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    lsu_split #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    assign bus_a.req_valid_i   = req_valid && !sel;
    assign bus_b.req_valid_i   = req_valid && sel;
    assign bus_a.dmem_ready_i  = mem_ready && !sel;
    assign bus_b.dmem_ready_i  = mem_ready && sel;
    assign bus_a.we_i          = we;
    assign bus_b.we_i          = we;
    assign bus_a.type_i        = ty;
    assign bus_b.type_i        = ty;
    assign bus_a.sign_extend_i = sext;
    assign bus_b.sign_extend_i = sext;
    assign bus_a.addr_i        = addr;
    assign bus_b.addr_i        = addr;
    assign bus_a.wdata_i       = wdata;
    assign bus_b.wdata_i       = wdata;
    assign bus_a.dmem_rdata_i  = mem_rdata;
    assign bus_b.dmem_rdata_i  = mem_rdata;

    logic        o_req_ready, o_resp_valid, o_err, o_dvalid;
    logic [31:0] o_rdata, o_daddr, o_dwdata;
    logic [3:0]  o_dwe;

    assign o_req_ready  = sel ? bus_b.req_ready_o  : bus_a.req_ready_o;
    assign o_resp_valid = sel ? bus_b.resp_valid_o : bus_a.resp_valid_o;
    assign o_err        = sel ? bus_b.err_o        : bus_a.err_o;
    assign o_rdata      = sel ? bus_b.rdata_o      : bus_a.rdata_o;
    assign o_dvalid     = sel ? bus_b.dmem_valid_o : bus_a.dmem_valid_o;
    assign o_daddr      = sel ? bus_b.dmem_addr_o  : bus_a.dmem_addr_o;
    assign o_dwdata     = sel ? bus_b.dmem_wdata_o : bus_a.dmem_wdata_o;
    assign o_dwe        = sel ? bus_b.dmem_we_o    : bus_a.dmem_we_o;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] t, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; we = w; ty = t; sext = s; addr = a; wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // nb = expected beat count (0 for the error path); wt = wait cycles before ready on beat 0.
    task automatic access(input string tag, input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input int nb, input int wt,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [3:0] ew0, input logic [3:0] ew1,
                          input logic [31:0] ed0, input logic [31:0] ed1,
                          input logic eerr, input logic [31:0] erd);
        check_eq({tag, ":req_ready"}, {31'b0, o_req_ready}, 32'd1);
        issue(w, t, s, a, wd);
        for (int b = 0; b < nb; b++) begin
            int wb;
            wb = (b == 0) ? wt : 0;
            for (int c = 0; c <= wb; c++) begin
                check_eq({tag, ":dvalid"}, {31'b0, o_dvalid}, 32'd1);
                check_eq({tag, ":daddr"}, o_daddr, (b == 0) ? ea0 : ea1);
                check_eq({tag, ":dwe"}, {28'b0, o_dwe}, {28'b0, (b == 0) ? ew0 : ew1});
                check_eq({tag, ":dwdata"}, o_dwdata, (b == 0) ? ed0 : ed1);
                if (c == wb) begin
                    mem_ready = 1'b1;
                    mem_rdata = (b == 0) ? rd0 : rd1;
                end
                tick();
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
        end
        check_eq({tag, ":resp_dvalid"}, {31'b0, o_dvalid}, 32'd0);
        check_eq({tag, ":resp_valid"}, {31'b0, o_resp_valid}, 32'd1);
        check_eq({tag, ":err"}, {31'b0, o_err}, {31'b0, eerr});
        check_eq({tag, ":rdata"}, o_rdata, erd);
        tick();
        check_eq({tag, ":resp_pulse"}, {31'b0, o_resp_valid}, 32'd0);
    endtask

    initial begin
        tick();
        check_eq("rst:req_ready", {31'b0, o_req_ready}, 32'd0);
        check_eq("rst:resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check_eq("rst:err", {31'b0, o_err}, 32'd0);
        check_eq("rst:dvalid", {31'b0, o_dvalid}, 32'd0);
        check_eq("rst:dwe", {28'b0, o_dwe}, 32'd0);
        check_eq("rst:rdata", o_rdata, 32'd0);
        check_eq("rst:daddr", o_daddr, 32'd0);
        check_eq("rst:dwdata", o_dwdata, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        sel = 1'b0;
        access("lw100", 1'b0, WORD, 1'b0, 32'h100, 32'h0, 1, 2, 32'hDEADBEEF, 32'h0,
               32'h100, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
        access("sb103", 1'b1, BYTE, 1'b0, 32'h103, 32'hA5, 1, 0, 32'h0, 32'h0,
               32'h100, 32'h0, 4'b1000, 4'b0000, 32'hA5000000, 32'h0, 1'b0, 32'h0);
        access("lw102", 1'b0, WORD, 1'b0, 32'h102, 32'h0, 2, 1, 32'h11223344, 32'h55667788,
               32'h100, 32'h104, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h77881122);
        access("sh103", 1'b1, HALF, 1'b0, 32'h103, 32'hBEEF, 2, 0, 32'h0, 32'h0,
               32'h100, 32'h104, 4'b1000, 4'b0001, 32'hEF000000, 32'h000000BE, 1'b0, 32'h0);
        access("lb_s101", 1'b0, BYTE, 1'b1, 32'h101, 32'h0, 1, 0, 32'h00008000, 32'h0,
               32'h100, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80);
        access("lbu102", 1'b0, BYTE, 1'b0, 32'h102, 32'h0, 1, 0, 32'h00F00000, 32'h0,
               32'h100, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h000000F0);
        access("lh_wrap", 1'b0, HALF, 1'b0, 32'hFFFFFFFF, 32'h0, 2, 0, 32'hAABBCCDD, 32'h11223344,
               32'hFFFFFFFC, 32'h00000000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h000044AA);
        access("illegal", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0,
               32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h0);
        access("tmo_edge", 1'b0, WORD, 1'b0, 32'h200, 32'h0, 1, 3, 32'hCAFEF00D, 32'h0,
               32'h200, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D);

        // Beat-0 timeout: valid for exactly four cycles, then an error response.
        issue(1'b0, WORD, 1'b0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo:dvalid", {31'b0, o_dvalid}, 32'd1);
            tick();
        end
        check_eq("tmo:dvalid_drop", {31'b0, o_dvalid}, 32'd0);
        check_eq("tmo:resp_valid", {31'b0, o_resp_valid}, 32'd1);
        check_eq("tmo:err", {31'b0, o_err}, 32'd1);
        check_eq("tmo:rdata", o_rdata, 32'd0);
        tick();

        // Beat-1 timeout on a split store; beat 0 completes normally.
        issue(1'b1, HALF, 1'b0, 32'h103, 32'hBEEF);
        check_eq("tmo1:beat0_addr", o_daddr, 32'h100);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo1:dvalid", {31'b0, o_dvalid}, 32'd1);
            check_eq("tmo1:daddr", o_daddr, 32'h104);
            tick();
        end
        check_eq("tmo1:dvalid_drop", {31'b0, o_dvalid}, 32'd0);
        check_eq("tmo1:resp_valid", {31'b0, o_resp_valid}, 32'd1);
        check_eq("tmo1:err", {31'b0, o_err}, 32'd1);
        tick();

        // Reset in the middle of a beat abandons the access silently.
        issue(1'b0, WORD, 1'b0, 32'h400, 32'h0);
        check_eq("rstmid:dvalid", {31'b0, o_dvalid}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rstmid:req_ready_in_rst", {31'b0, o_req_ready}, 32'd0);
        tick();
        check_eq("rstmid:dvalid_drop", {31'b0, o_dvalid}, 32'd0);
        check_eq("rstmid:resp_valid", {31'b0, o_resp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rstmid:req_ready_after", {31'b0, o_req_ready}, 32'd1);
        tick();
        check_eq("rstmid:no_resp", {31'b0, o_resp_valid}, 32'd0);

        sel = 1'b1;
        #1;
        access("nomis_lh103", 1'b0, HALF, 1'b0, 32'h103, 32'h0, 0, 0, 32'h0, 32'h0,
               32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h0);
        access("notmo_lh102", 1'b0, HALF, 1'b1, 32'h102, 32'h0, 1, 6, 32'h80010000, 32'h0,
               32'h100, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hFFFF8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
